// File: rtl/core_pkg.sv
// core_pkg: shared branch funct3 encodings, BHT counter type and the taken decode.
package core_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_RESET = 2'b01;

    // funct3 bit0 inverts the base test; 010/011 are not branches and resolve not taken
    function automatic logic branch_taken(input logic [2:0] f3, input logic less, input logic equal);
        return f3[2] ? (less ^ f3[0]) : (f3[1] ? 1'b0 : (equal ^ f3[0]));
    endfunction

    function automatic logic branch_illegal(input logic [2:0] f3);
        return f3 == 3'b010 || f3 == 3'b011;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: array of 2-bit saturating direction counters.
//   clk, rst_n        clock, async active-low reset (all counters to BHT_RESET)
//   rd_idx / rd_taken combinational lookup, returns counter MSB
//   wr_en, wr_idx     update strobe and index
//   wr_taken          1 = count up, 0 = count down (both saturate)
module bht_2bit
    import core_pkg::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_ctr_t ctr [ENTRIES];
    bht_ctr_t cur;

    // reads see the stored value; a same-cycle write lands only at the edge
    assign rd_taken = ctr[rd_idx][1];
    assign cur = ctr[wr_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= BHT_RESET;
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_taken ? (cur == 2'b11 ? cur : cur + 2'd1)
                                    : (cur == 2'b00 ? cur : cur - 2'd1);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: EX-stage branch/jump resolution, registered redirect, BHT and perf counters.
//   ex_*            EX instruction, its prediction and comparator flags (br_less/br_equal)
//   br_unsigned     comparator mode select, straight from funct3[1]
//   if_pc           IF lookup address -> if_pred_taken
//   redirect_valid/redirect_pc/flush   one-cycle registered redirect on mispredict
//   illegal_br      one-cycle pulse for a resolved branch with funct3 010/011
//   branch_cnt/mispred_cnt             resolved branches and branch mispredicts
module branch_resolve_unit
    import core_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic             br_less,
    input  logic             br_equal,
    output logic             br_unsigned,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             illegal_br,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic        resolve, br_tk, br_ill, br_mis, jalr_only, taken, mispred;
    logic [31:0] target;
    logic        unused_pc;

    assign br_unsigned = ex_funct3[1];
    assign br_tk       = branch_taken(ex_funct3, br_less, br_equal);
    assign br_ill      = branch_illegal(ex_funct3);
    assign br_mis      = br_tk != ex_pred_taken;
    // the cycle after a redirect carries a wrong-path instruction; ignore it
    assign resolve     = ex_valid & !ex_stall & !redirect_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
    assign jalr_only   = ex_is_jalr & !ex_is_branch & !ex_is_jal;
    assign taken       = !ex_is_branch | br_tk;
    assign mispred     = ex_is_branch ? br_mis : (ex_is_jal ? !ex_pred_taken : 1'b1);
    assign target      = taken ? {ex_target[31:1], ex_target[0] & !jalr_only} : ex_pc + 32'd4;
    assign unused_pc   = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    bht_2bit #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_taken (if_pred_taken),
        .wr_en    (resolve & ex_is_branch & !br_ill),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (br_tk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            illegal_br     <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else begin
            redirect_valid <= resolve & mispred;
            flush          <= resolve & mispred;
            illegal_br     <= resolve & ex_is_branch & br_ill;
            if (resolve & mispred) redirect_pc <= target;
            if (resolve & ex_is_branch) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
                if (br_mis) mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed plus random check of branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

    logic        clk = 0, rst_n = 0;
    logic        ex_valid = 0, ex_stall = 0, ex_is_branch = 0, ex_is_jal = 0, ex_is_jalr = 0;
    logic [2:0]  ex_funct3 = 0;
    logic [31:0] ex_pc = 0, ex_target = 0, if_pc = 0;
    logic        ex_pred_taken = 0, br_less = 0, br_equal = 0;
    logic        br_unsigned, if_pred_taken, redirect_valid, flush, illegal_br;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

    int checks = 0, failures = 0;

    // reference state
    int          m_bht [64];
    bit          m_rv, m_ill;
    logic [31:0] m_rpc, m_bc, m_mc;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_stall(ex_stall),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .br_less(br_less), .br_equal(br_equal),
        .br_unsigned(br_unsigned), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .illegal_br(illegal_br), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_taken(input int f3, input bit lt, input bit eq);
        case (f3)
            0: return eq;
            1: return !eq;
            4, 6: return lt;
            5, 7: return !lt;
            default: return 0;
        endcase
    endfunction

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    task automatic model_reset();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_rv = 0; m_ill = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic check_regs();
        chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        chk("flush", 32'(flush), 32'(m_rv));
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("illegal_br", 32'(illegal_br), 32'(m_ill));
        chk("branch_cnt", branch_cnt, m_bc);
        chk("mispred_cnt", mispred_cnt, m_mc);
    endtask

    // kind: 0 none, 1 branch, 2 jal, 3 jalr; one EX cycle, checked before and after the edge
    task automatic step(input bit v, input bit st, input int kind, input int f3,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit pred,
                        input bit lt, input bit eq, input logic [31:0] ipc);
        bit res, tk, ill, mis;
        ex_valid = v; ex_stall = st; ex_is_branch = kind == 1; ex_is_jal = kind == 2;
        ex_is_jalr = kind == 3; ex_funct3 = 3'(f3); ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pred; br_less = lt; br_equal = eq; if_pc = ipc;
        @(negedge clk);
        chk("br_unsigned", 32'(br_unsigned), 32'(f3 == 6 || f3 == 7 || f3 == 2 || f3 == 3));
        chk("if_pred_taken", 32'(if_pred_taken), 32'(m_bht[slot(ipc)] >= 2));
        res = v && !st && !m_rv && kind != 0;
        tk  = kind == 1 ? ref_taken(f3, lt, eq) : 1;
        ill = kind == 1 && (f3 == 2 || f3 == 3);
        mis = kind == 1 ? tk != pred : kind == 2 ? !pred : 1;
        m_rv  = res && mis;
        m_ill = res && ill;
        if (m_rv) m_rpc = !tk ? pc + 32'd4 : kind == 3 ? tgt & ~32'd1 : tgt;
        if (res && kind == 1) begin
            m_bc++;
            if (mis) m_mc++;
            if (!ill) m_bht[slot(pc)] = tk ? (m_bht[slot(pc)] == 3 ? 3 : m_bht[slot(pc)] + 1)
                                           : (m_bht[slot(pc)] == 0 ? 0 : m_bht[slot(pc)] - 1);
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ipc);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check_regs();
        idle(32'h100);

        // BEQ taken, predicted not taken
        step(1, 0, 1, 0, 32'h200, 32'h240, 0, 0, 1, 32'h200);
        chk("beq_rpc", redirect_pc, 32'h240);
        chk("beq_flush", 32'(flush), 1);
        idle(32'h200);
        chk("bht_200_taken", 32'(m_bht[slot(32'h200)]), 2);

        // BGE / BGEU not taken, predicted taken
        step(1, 0, 1, 5, 32'h300, 32'h380, 1, 1, 0, 0);
        chk("bge_rpc", redirect_pc, 32'h304);
        idle(0);
        step(1, 0, 1, 7, 32'h300, 32'h380, 1, 1, 0, 0);
        idle(0);

        // BNE taken three times, predicted taken: saturate, no redirects
        repeat (3) step(1, 0, 1, 1, 32'h400, 32'h500, 1, 0, 0, 32'h400);
        idle(32'h400);

        // JALR clears bit0; the next cycle is wrong-path and ignored
        step(1, 0, 3, 0, 32'h600, 32'h1235, 1, 0, 0, 0);
        chk("jalr_rpc", redirect_pc, 32'h1234);
        step(1, 0, 1, 0, 32'h700, 32'h800, 0, 0, 1, 32'h700);
        chk("wrongpath_rv", 32'(redirect_valid), 0);

        // JAL predicted / unpredicted
        step(1, 0, 2, 0, 32'h900, 32'hA00, 1, 0, 0, 0);
        step(1, 0, 2, 0, 32'h900, 32'hA00, 0, 0, 0, 0);
        idle(0);

        // illegal funct3, stalled mispredict, wrap of pc+4
        step(1, 0, 1, 2, 32'h200, 32'h0, 0, 1, 1, 32'h200);
        chk("illegal_pulse", 32'(illegal_br), 1);
        idle(32'h200);
        step(1, 1, 1, 0, 32'h200, 32'h240, 0, 0, 1, 32'h200);
        step(1, 0, 1, 0, 32'hFFFFFFFC, 32'h40, 1, 0, 0, 0);
        chk("wrap_rpc", redirect_pc, 32'h0);

        // async reset while redirect_valid is high
        step(1, 0, 1, 0, 32'h200, 32'h240, 0, 0, 1, 32'h200);
        rst_n = 0;
        #1;
        model_reset();
        check_regs();
        @(posedge clk);
        #1 rst_n = 1;
        idle(32'h200);
        idle(32'h400);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc, ipc;
            pc  = 32'(($urandom_range(0, 15)) * 4 + 32'h1000 * $urandom_range(0, 1));
            ipc = 32'(($urandom_range(0, 15)) * 4);
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 15, $urandom_range(0, 3),
                 $urandom_range(0, 7), pc, $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), ipc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
